scv_vram_arbiter: RTL and testbench

//  Shares one single-port synchronous VRAM between the uPD7800 CPU bus and the video fetch engine.

---
 rtl/scv_vram_pkg.sv | 26 ++
 rtl/scv_strobe_edge.sv | 35 +++
 rtl/scv_vram_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_scv_vram_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/scv_vram_pkg.sv
// Shared types and constants for the SCV VRAM arbiter.
//   rd_state_t : CPU read tracker states
//   grant_t    : owner of the single VRAM slot in a cycle
//   VRAM_AW    : VRAM address width (8 KB window)
//   VRAM_DW    : VRAM data width
package scv_vram_pkg;

    localparam int unsigned VRAM_AW = 13;
    localparam int unsigned VRAM_DW = 8;

    typedef enum logic [2:0] {
        RD_IDLE,
        RD_PEND,
        RD_ISSUED,
        RD_DATA,
        RD_FWD
    } rd_state_t;

    typedef enum logic [1:0] {
        G_NONE,
        G_VID,
        G_CPU_RD,
        G_CPU_WR
    } grant_t;

endpackage

// File: rtl/scv_strobe_edge.sv
// Registered falling-edge detect of the CPU read/write strobes, qualified by
// the VRAM window chip-select. Both strobes low together produce no event.
//   clk, rst   : clock, synchronous active-high reset
//   cs         : VRAM window selected
//   rdb, wrb   : CPU read/write strobes, active low
//   rd_evt_c   : combinational read event this cycle
//   wr_evt_c   : combinational write event this cycle
module scv_strobe_edge (
    input  logic clk,
    input  logic rst,
    input  logic cs,
    input  logic rdb,
    input  logic wrb,
    output logic rd_evt_c,
    output logic wr_evt_c
);

    logic rdb_q;
    logic wrb_q;

    // Previous strobe levels; idle-high after reset so no spurious edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdb_q <= 1'b1;
            wrb_q <= 1'b1;
        end else begin
            rdb_q <= rdb;
            wrb_q <= wrb;
        end
    end

    assign rd_evt_c = cs & rdb_q & ~rdb & wrb;
    assign wr_evt_c = cs & wrb_q & ~wrb & rdb;

endmodule

// File: rtl/scv_vram_arbiter.sv
// Shares one single-port synchronous VRAM between the CPU bus and the video
// fetch engine. Video has fixed priority; CPU writes are posted through a
// one-entry buffer; CPU reads stall via CPU_WAIT; a starvation counter forces
// a CPU slot after STARVE_LIMIT consecutive denied cycles.
//   CLK, RES            : clock, synchronous active-high reset
//   CPU_CS/RDB/WRB/A/DI : CPU bus side (strobes active low)
//   CPU_DO, CPU_WAIT    : CPU read data (held), CPU cycle extension
//   VID_REQ/A           : video read request (level) and address
//   VID_ACK             : combinational request accept
//   VID_RVALID/RDATA    : video read data return
//   RAM_A/WE/DI         : registered VRAM controls
//   RAM_DO              : VRAM read data, valid the cycle after RAM_A
module scv_vram_arbiter
    import scv_vram_pkg::*;
#(
    parameter int unsigned AW           = VRAM_AW,
    parameter int unsigned DW           = VRAM_DW,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic          CLK,
    input  logic          RES,
    input  logic          CPU_CS,
    input  logic          CPU_RDB,
    input  logic          CPU_WRB,
    input  logic [AW-1:0] CPU_A,
    input  logic [DW-1:0] CPU_DI,
    output logic [DW-1:0] CPU_DO,
    output logic          CPU_WAIT,
    input  logic          VID_REQ,
    input  logic [AW-1:0] VID_A,
    output logic          VID_ACK,
    output logic          VID_RVALID,
    output logic [DW-1:0] VID_RDATA,
    output logic [AW-1:0] RAM_A,
    output logic          RAM_WE,
    output logic [DW-1:0] RAM_DI,
    input  logic [DW-1:0] RAM_DO
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    rd_state_t     rd_state;
    rd_state_t     rd_state_next;
    grant_t        grant_c;

    logic          rd_evt_c;
    logic          wr_evt_c;
    logic          rd_hit_c;
    logic          rd_req_c;
    logic          cpu_pend_c;
    logic          forced_c;
    logic          drain_c;
    logic          wr2_next_c;

    logic [AW-1:0] rd_addr;
    logic [DW-1:0] fwd_data;
    logic          wbuf_valid;
    logic [AW-1:0] wbuf_addr;
    logic [DW-1:0] wbuf_data;
    logic          wr2_valid;
    logic [AW-1:0] wr2_addr;
    logic [DW-1:0] wr2_data;
    logic [SW-1:0] starve_cnt;
    logic          vid_p1;

    scv_strobe_edge u_strobe_edge (
        .clk      (CLK),
        .rst      (RES),
        .cs       (CPU_CS),
        .rdb      (CPU_RDB),
        .wrb      (CPU_WRB),
        .rd_evt_c (rd_evt_c),
        .wr_evt_c (wr_evt_c)
    );

    // Arbitration: forced CPU > video > pending read > buffered write.
    // A read hitting the write buffer is served by forwarding, never by RAM.
    always_comb begin
        grant_c    = G_NONE;
        rd_hit_c   = (rd_state == RD_PEND) && wbuf_valid && (wbuf_addr == rd_addr);
        rd_req_c   = (rd_state == RD_PEND) && !rd_hit_c;
        cpu_pend_c = rd_req_c || wbuf_valid;
        forced_c   = cpu_pend_c && (starve_cnt == SW'(STARVE_LIMIT));
        if (forced_c) begin
            grant_c = rd_req_c ? G_CPU_RD : G_CPU_WR;
        end else if (VID_REQ) begin
            grant_c = G_VID;
        end else if (rd_req_c) begin
            grant_c = G_CPU_RD;
        end else if (wbuf_valid) begin
            grant_c = G_CPU_WR;
        end
        drain_c    = (grant_c == G_CPU_WR);
        // Second write waits only while the first is still undrained.
        wr2_next_c = (wr2_valid || (wr_evt_c && wbuf_valid)) && !drain_c;
    end

    assign VID_ACK   = VID_REQ & ~forced_c;
    assign VID_RDATA = RAM_DO;

    // Read tracker next state.
    always_comb begin
        rd_state_next = rd_state;
        case (rd_state)
            RD_IDLE:   if (rd_evt_c) rd_state_next = RD_PEND;
            RD_PEND: begin
                if (rd_hit_c)                  rd_state_next = RD_FWD;
                else if (grant_c == G_CPU_RD)  rd_state_next = RD_ISSUED;
            end
            RD_ISSUED: rd_state_next = RD_DATA;
            RD_DATA:   rd_state_next = RD_IDLE;
            RD_FWD:    rd_state_next = RD_IDLE;
            default:   rd_state_next = RD_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RES) rd_state <= RD_IDLE;
        else     rd_state <= rd_state_next;
    end

    // Datapath: write buffer, read capture, starvation counter, RAM regs.
    always_ff @(posedge CLK) begin
        if (RES) begin
            rd_addr    <= '0;
            fwd_data   <= '0;
            wbuf_valid <= 1'b0;
            wbuf_addr  <= '0;
            wbuf_data  <= '0;
            wr2_valid  <= 1'b0;
            wr2_addr   <= '0;
            wr2_data   <= '0;
            starve_cnt <= '0;
            vid_p1     <= 1'b0;
            VID_RVALID <= 1'b0;
            CPU_DO     <= '0;
            CPU_WAIT   <= 1'b0;
            RAM_A      <= '0;
            RAM_WE     <= 1'b0;
            RAM_DI     <= '0;
        end else begin
            // New write goes straight in if the slot is free or freeing now.
            if (wr_evt_c && (!wbuf_valid || drain_c)) begin
                wbuf_valid <= 1'b1;
                wbuf_addr  <= CPU_A;
                wbuf_data  <= CPU_DI;
            end else if (drain_c && wr2_valid) begin
                wbuf_valid <= 1'b1;
                wbuf_addr  <= wr2_addr;
                wbuf_data  <= wr2_data;
            end else if (drain_c) begin
                wbuf_valid <= 1'b0;
            end
            if (wr_evt_c && wbuf_valid && !drain_c) begin
                wr2_addr <= CPU_A;
                wr2_data <= CPU_DI;
            end
            wr2_valid <= wr2_next_c;

            if (rd_evt_c && (rd_state == RD_IDLE)) rd_addr <= CPU_A;
            if (rd_hit_c) fwd_data <= wbuf_data;
            if (rd_state == RD_DATA)     CPU_DO <= RAM_DO;
            else if (rd_state == RD_FWD) CPU_DO <= fwd_data;
            CPU_WAIT <= (rd_state_next != RD_IDLE) || wr2_next_c;

            if ((grant_c == G_CPU_RD) || (grant_c == G_CPU_WR) || !cpu_pend_c) begin
                starve_cnt <= '0;
            end else if (starve_cnt != SW'(STARVE_LIMIT)) begin
                starve_cnt <= starve_cnt + SW'(1);
            end

            RAM_WE <= drain_c;
            case (grant_c)
                G_VID:    RAM_A <= VID_A;
                G_CPU_RD: RAM_A <= rd_addr;
                G_CPU_WR: begin
                    RAM_A  <= wbuf_addr;
                    RAM_DI <= wbuf_data;
                end
                default:  ;
            endcase
            vid_p1     <= (grant_c == G_VID);
            VID_RVALID <= vid_p1;
        end
    end

endmodule

// File: tb/tb_scv_vram_arbiter.sv
// Directed self-checking bench for scv_vram_arbiter with a behavioural
// single-port synchronous VRAM model.
module tb_scv_vram_arbiter;

    logic        clk;
    logic        res;
    logic        cpu_cs;
    logic        cpu_rdb;
    logic        cpu_wrb;
    logic [12:0] cpu_a;
    logic [7:0]  cpu_di;
    logic [7:0]  cpu_do;
    logic        cpu_wait;
    logic        vid_req;
    logic [12:0] vid_a;
    logic        vid_ack;
    logic        vid_rvalid;
    logic [7:0]  vid_rdata;
    logic [12:0] ram_a;
    logic        ram_we;
    logic [7:0]  ram_di;
    logic [7:0]  ram_do;

    int checks = 0;
    int errors = 0;

    scv_vram_arbiter #(.AW(13), .DW(8), .STARVE_LIMIT(4)) dut (
        .CLK        (clk),
        .RES        (res),
        .CPU_CS     (cpu_cs),
        .CPU_RDB    (cpu_rdb),
        .CPU_WRB    (cpu_wrb),
        .CPU_A      (cpu_a),
        .CPU_DI     (cpu_di),
        .CPU_DO     (cpu_do),
        .CPU_WAIT   (cpu_wait),
        .VID_REQ    (vid_req),
        .VID_A      (vid_a),
        .VID_ACK    (vid_ack),
        .VID_RVALID (vid_rvalid),
        .VID_RDATA  (vid_rdata),
        .RAM_A      (ram_a),
        .RAM_WE     (ram_we),
        .RAM_DI     (ram_di),
        .RAM_DO     (ram_do)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // VRAM model: preloaded contents plus everything written so far.
    logic [7:0] mem [int];

    function automatic logic [7:0] init_val(input logic [12:0] a);
        case (a)
            13'h000: return 8'h10;
            13'h001: return 8'h11;
            13'h002: return 8'h12;
            13'h300: return 8'hA5;
            13'h500: return 8'h3C;
            13'h501: return 8'h4D;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] rd_val(input logic [12:0] a);
        if (mem.exists(int'(a))) return mem[int'(a)];
        return init_val(a);
    endfunction

    always @(posedge clk) begin
        ram_do <= rd_val(ram_a);
        if (ram_we) mem[int'(ram_a)] = ram_di;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        res = 1'b1; cpu_cs = 1'b0; cpu_rdb = 1'b1; cpu_wrb = 1'b1;
        cpu_a = '0; cpu_di = '0; vid_req = 1'b0; vid_a = '0;

        // Reset state
        cyc(); cyc(); cyc();
        #1;
        chk("rst_cpu_do", 16'(cpu_do), 16'h0);
        chk("rst_cpu_wait", 16'(cpu_wait), 16'h0);
        chk("rst_vid_ack", 16'(vid_ack), 16'h0);
        chk("rst_vid_rvalid", 16'(vid_rvalid), 16'h0);
        chk("rst_ram_a", 16'(ram_a), 16'h0);
        chk("rst_ram_we", 16'(ram_we), 16'h0);
        chk("rst_ram_di", 16'(ram_di), 16'h0);
        res = 1'b0;

        // Video burst of three reads, two-cycle return latency
        for (int k = 0; k < 6; k++) begin
            cyc();
            vid_req = (k < 3);
            vid_a   = 13'(k);
            #1;
            if (k < 3) chk("t1_ack", 16'(vid_ack), 16'h1);
            if (k >= 2 && k < 5) begin
                chk("t1_rvalid", 16'(vid_rvalid), 16'h1);
                chk("t1_rdata", 16'(vid_rdata), 16'(16'h10 + k - 2));
            end
            if (k == 5) chk("t1_rvalid_end", 16'(vid_rvalid), 16'h0);
        end

        // Posted write with video idle
        for (int k = 0; k < 5; k++) begin
            cyc();
            if (k == 0) begin cpu_cs = 1'b1; cpu_wrb = 1'b0; cpu_a = 13'h100; cpu_di = 8'h5A; end
            if (k == 2) begin cpu_wrb = 1'b1; cpu_cs = 1'b0; end
            #1;
            chk("t2_wait", 16'(cpu_wait), 16'h0);
            chk("t2_we", 16'(ram_we), (k == 2) ? 16'h1 : 16'h0);
            if (k == 2) begin
                chk("t2_ram_a", 16'(ram_a), 16'h100);
                chk("t2_ram_di", 16'(ram_di), 16'h5A);
            end
        end
        chk("t2_mem", 16'(rd_val(13'h100)), 16'h5A);

        // Write then read same address under video: forwarded, no RAM read
        for (int k = 0; k < 8; k++) begin
            cyc();
            if (k == 0) begin
                vid_req = 1'b1; vid_a = 13'h020;
                cpu_cs = 1'b1; cpu_wrb = 1'b0; cpu_a = 13'h200; cpu_di = 8'h77;
            end
            if (k == 1) begin cpu_wrb = 1'b1; cpu_rdb = 1'b0; end
            if (k == 3) begin cpu_rdb = 1'b1; cpu_cs = 1'b0; end
            if (k == 7) vid_req = 1'b0;
            #1;
            if (k == 2 || k == 3) chk("t3_wait", 16'(cpu_wait), 16'h1);
            if (k == 4) begin
                chk("t3_wait_clr", 16'(cpu_wait), 16'h0);
                chk("t3_cpu_do", 16'(cpu_do), 16'h77);
            end
            if (k >= 1 && k <= 5) begin
                chk("t3_ram_a_vid", 16'(ram_a), 16'h020);
                chk("t3_we_idle", 16'(ram_we), 16'h0);
            end
            if (k >= 1 && k <= 4) chk("t3_ack", 16'(vid_ack), 16'h1);
            if (k == 5) chk("t3_ack_forced", 16'(vid_ack), 16'h0);
            if (k == 6) begin
                chk("t3_we", 16'(ram_we), 16'h1);
                chk("t3_ram_a", 16'(ram_a), 16'h200);
                chk("t3_ram_di", 16'(ram_di), 16'h77);
            end
        end

        // Starved read under continuous video
        for (int k = 0; k < 10; k++) begin
            cyc();
            if (k == 0) begin
                vid_req = 1'b1; vid_a = 13'h030;
                cpu_cs = 1'b1; cpu_rdb = 1'b0; cpu_a = 13'h300;
            end
            if (k == 9) begin vid_req = 1'b0; cpu_rdb = 1'b1; cpu_cs = 1'b0; end
            #1;
            if (k <= 6) chk("t4_ack", 16'(vid_ack), (k == 5) ? 16'h0 : 16'h1);
            if (k >= 1 && k <= 7) chk("t4_wait", 16'(cpu_wait), 16'h1);
            if (k == 6) chk("t4_ram_a", 16'(ram_a), 16'h300);
            if (k == 7) chk("t4_cpu_do_held", 16'(cpu_do), 16'h77);
            if (k == 8) begin
                chk("t4_wait_clr", 16'(cpu_wait), 16'h0);
                chk("t4_cpu_do", 16'(cpu_do), 16'hA5);
            end
        end

        // Second write while buffer full under continuous video
        for (int k = 0; k < 13; k++) begin
            cyc();
            if (k == 0) begin
                vid_req = 1'b1; vid_a = 13'h040;
                cpu_cs = 1'b1; cpu_wrb = 1'b0; cpu_a = 13'h400; cpu_di = 8'h11;
            end
            if (k == 1) cpu_wrb = 1'b1;
            if (k == 2) begin cpu_wrb = 1'b0; cpu_a = 13'h401; cpu_di = 8'h22; end
            if (k == 7) begin cpu_wrb = 1'b1; cpu_cs = 1'b0; end
            if (k == 12) vid_req = 1'b0;
            #1;
            if (k <= 6) chk("t5_wait", 16'(cpu_wait), (k >= 3 && k <= 5) ? 16'h1 : 16'h0);
            if (k <= 11) chk("t5_ack", 16'(vid_ack), (k == 5 || k == 10) ? 16'h0 : 16'h1);
            chk("t5_we", 16'(ram_we), (k == 6 || k == 11) ? 16'h1 : 16'h0);
            if (k == 6) begin
                chk("t5_ram_a1", 16'(ram_a), 16'h400);
                chk("t5_ram_di1", 16'(ram_di), 16'h11);
            end
            if (k == 11) begin
                chk("t5_ram_a2", 16'(ram_a), 16'h401);
                chk("t5_ram_di2", 16'(ram_di), 16'h22);
            end
        end
        chk("t5_mem1", 16'(rd_val(13'h400)), 16'h11);
        chk("t5_mem2", 16'(rd_val(13'h401)), 16'h22);

        // Reset while a CPU read is in flight, then a clean read
        for (int k = 0; k < 10; k++) begin
            cyc();
            if (k == 0) begin cpu_cs = 1'b1; cpu_rdb = 1'b0; cpu_a = 13'h500; end
            if (k == 2) res = 1'b1;
            if (k == 3) begin res = 1'b0; cpu_rdb = 1'b1; cpu_cs = 1'b0; end
            if (k == 4) begin cpu_cs = 1'b1; cpu_rdb = 1'b0; cpu_a = 13'h501; end
            if (k == 9) begin cpu_rdb = 1'b1; cpu_cs = 1'b0; end
            #1;
            if (k == 2) chk("t6_issued_addr", 16'(ram_a), 16'h500);
            if (k == 3) begin
                chk("t6_rst_cpu_do", 16'(cpu_do), 16'h0);
                chk("t6_rst_wait", 16'(cpu_wait), 16'h0);
                chk("t6_rst_ack", 16'(vid_ack), 16'h0);
                chk("t6_rst_rvalid", 16'(vid_rvalid), 16'h0);
                chk("t6_rst_ram_a", 16'(ram_a), 16'h0);
                chk("t6_rst_ram_we", 16'(ram_we), 16'h0);
                chk("t6_rst_ram_di", 16'(ram_di), 16'h0);
            end
            if (k >= 5 && k <= 7) begin
                chk("t6_no_stale", 16'(cpu_do), 16'h0);
                chk("t6_wait", 16'(cpu_wait), 16'h1);
            end
            if (k == 8) begin
                chk("t6_cpu_do", 16'(cpu_do), 16'h4D);
                chk("t6_wait_clr", 16'(cpu_wait), 16'h0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
